debug_unit: RTL and testbench

DEBUG_UNIT -- requirements
Module: debug_unit

---
 rtl/debug_pkg.sv | 27 ++
 rtl/debug_sync_edge.sv | 30 +++
 rtl/debug_unit.sv | 93 +++++++++
 tb/tb_debug_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the debug run/step controller: state encoding and
// the default opcode width / halt opcode.
package debug_pkg;

  localparam int DEF_OPCODE_W = 5;
  localparam logic [DEF_OPCODE_W-1:0] DEF_HALT_OPCODE = 5'b11111;

  // 2'b11 is deliberately left unused; the FSM recovers from it to STOPPED.
  typedef enum logic [1:0] {
    STOPPED = 2'b00,
    RUN     = 2'b01,
    STEP    = 2'b10
  } state_t;

  // The processor counts as stopped in every state except RUN.
  function automatic logic state_is_stopped(input state_t s);
    logic res;
    case (s)
      RUN:     res = 1'b0;
      STOPPED: res = 1'b1;
      STEP:    res = 1'b1;
      default: res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/debug_sync_edge.sv
// Two-flop synchronizer for an asynchronous request line followed by a
// rising-edge detector producing a single one-cycle pulse per edge.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  // Cleared flops at reset make a line already high at release look like an edge.
  assign pulse = sync & ~sync_d;

endmodule

// File: rtl/debug_unit.sv
// Debug run/step controller: gates PC advance from synchronized start/step
// requests and stops on the halt opcode.
module debug_unit
  import debug_pkg::*;
#(
  parameter int                  OPCODE_W    = DEF_OPCODE_W,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = DEF_HALT_OPCODE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                step,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                pc_enabled,
  output logic                stopped
);

  logic   start_p;
  logic   step_p;
  logic   is_halt;
  state_t state;
  state_t next_state;

  sync_edge u_start_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (start),
    .pulse    (start_p)
  );

  sync_edge u_step_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (step),
    .pulse    (step_p)
  );

  assign is_halt = (opcode == HALT_OPCODE);

  // Next-state decode; start wins over step, requests are ignored while running.
  always_comb begin
    next_state = STOPPED;
    case (state)
      STOPPED: begin
        if (start_p) begin
          next_state = RUN;
        end else if (step_p) begin
          next_state = STEP;
        end else begin
          next_state = STOPPED;
        end
      end
      RUN: begin
        if (is_halt) begin
          next_state = STOPPED;
        end else begin
          next_state = RUN;
        end
      end
      STEP:    next_state = STOPPED;
      default: next_state = STOPPED;
    endcase
  end

  // State register; stopped is registered from the next state so it tracks state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= STOPPED;
      stopped <= 1'b1;
    end else begin
      state   <= next_state;
      stopped <= state_is_stopped(next_state);
    end
  end

  // PC may not advance in the very cycle a halt opcode shows up while running.
  always_comb begin
    pc_enabled = 1'b0;
    case (state)
      RUN: begin
        if (is_halt) begin
          pc_enabled = 1'b0;
        end else begin
          pc_enabled = 1'b1;
        end
      end
      STEP:    pc_enabled = 1'b1;
      STOPPED: pc_enabled = 1'b0;
      default: pc_enabled = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: per-cycle expected outputs are queued as
// stimulus is driven and compared at the following falling clock edge.
module tb_debug_unit;

  localparam logic [4:0] HALT = 5'b11111;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       step;
  logic [4:0] opcode;
  logic       pc_enabled;
  logic       stopped;

  int checks = 0;
  int errors = 0;

  string      tag_q[$];
  logic [1:0] exp_q[$];

  debug_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .step       (step),
    .opcode     (opcode),
    .pc_enabled (pc_enabled),
    .stopped    (stopped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue the expected outputs.
  task automatic cyc(input logic s, input logic st, input logic [4:0] op,
                     input logic e_stop, input logic e_pc, input string tag);
    @(posedge clk);
    #1;
    start  = s;
    step   = st;
    opcode = op;
    tag_q.push_back(tag);
    exp_q.push_back({e_stop, e_pc});
  endtask

  // Monitor: compare outputs mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      automatic string      t = tag_q.pop_front();
      automatic logic [1:0] e = exp_q.pop_front();
      check({t, "_stopped"}, 32'(stopped), 32'(e[1]));
      check({t, "_pc_en"}, 32'(pc_enabled), 32'(e[0]));
    end
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    step   = 1'b0;
    opcode = 5'd0;
    #12;
    check("reset_stopped", 32'(stopped), 32'd1);
    check("reset_pc_en", 32'(pc_enabled), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset, then opcode changes while stopped
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "idle");
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, (i == 2) ? HALT : 5'(i * 5), 1'b1, 1'b0, "idle_op");

    // Start then halt
    cyc(1'b1, 1'b0, 5'd0, 1'b1, 1'b0, "start_lat0");
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "start_lat1");
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "start_lat2");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 5'(i + 1), 1'b0, 1'b1, "run");
    cyc(1'b0, 1'b0, HALT, 1'b0, 1'b0, "halt_same");
    cyc(1'b0, 1'b0, HALT, 1'b1, 1'b0, "halt_next");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "halted");

    // Restart with start held high for 20 cycles: only one restart
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 5'd0, 1'b1, 1'b0, "hold_lat");
    for (int i = 3; i < 10; i++) cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, "hold_run");
    cyc(1'b1, 1'b0, HALT, 1'b0, 1'b0, "hold_halt");
    for (int i = 11; i < 20; i++) cyc(1'b1, 1'b0, 5'd0, 1'b1, 1'b0, "hold_norestart");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "hold_release");

    // Three single steps
    for (int n = 0; n < 3; n++) begin
      automatic logic [4:0] op = (n == 0) ? 5'd0 : ((n == 1) ? 5'd3 : 5'd7);
      cyc(1'b0, 1'b1, op, 1'b1, 1'b0, "step_lat0");
      cyc(1'b0, 1'b0, op, 1'b1, 1'b0, "step_lat1");
      cyc(1'b0, 1'b0, op, 1'b1, 1'b0, "step_lat2");
      cyc(1'b0, 1'b0, op, 1'b1, 1'b1, "step_pulse");
      cyc(1'b0, 1'b0, op, 1'b1, 1'b0, "step_after");
      cyc(1'b0, 1'b0, op, 1'b1, 1'b0, "step_gap");
    end

    // Start and step together: start wins, step is not replayed
    cyc(1'b1, 1'b1, 5'd0, 1'b1, 1'b0, "prio_lat0");
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "prio_lat1");
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "prio_lat2");
    cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, "prio_run0");
    cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, "prio_run1");
    cyc(1'b0, 1'b0, HALT, 1'b0, 1'b0, "prio_halt");
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "prio_stopped0");
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "prio_stopped1");

    // Start while the halt opcode is present: one RUN cycle, PC never enabled
    cyc(1'b1, 1'b0, HALT, 1'b1, 1'b0, "rh_lat0");
    cyc(1'b0, 1'b0, HALT, 1'b1, 1'b0, "rh_lat1");
    cyc(1'b0, 1'b0, HALT, 1'b1, 1'b0, "rh_lat2");
    cyc(1'b0, 1'b0, HALT, 1'b0, 1'b0, "rh_run");
    cyc(1'b0, 1'b0, HALT, 1'b1, 1'b0, "rh_stop0");
    cyc(1'b0, 1'b0, HALT, 1'b1, 1'b0, "rh_stop1");

    // Mid-run asynchronous reset
    cyc(1'b1, 1'b0, 5'd0, 1'b1, 1'b0, "mr_lat0");
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "mr_lat1");
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "mr_lat2");
    cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, "mr_run");
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mr_async_stopped", 32'(stopped), 32'd1);
    check("mr_async_pc_en", 32'(pc_enabled), 32'd0);
    @(posedge clk);
    #1;
    check("mr_held_stopped", 32'(stopped), 32'd1);
    check("mr_held_pc_en", 32'(pc_enabled), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "mr_after");
    cyc(1'b1, 1'b0, 5'd0, 1'b1, 1'b0, "mr_rs_lat0");
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "mr_rs_lat1");
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "mr_rs_lat2");
    cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, "mr_rs_run");

    @(negedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
